p_result_uart: RTL

Downstream stage of the PRESENT core. It accepts one 64-bit cipher result through a valid/ready handshake and transmits it over a UART TX line as 16 uppercase ASCII hex characters, most significant nibble first. It sits between the `p` core output (`result[0:63]`) and the board UART pin, replacing the single-bit pass/fail compare output with the full ciphertext.

---
 rtl/p_result_uart_if.sv | 26 ++
 rtl/p_result_uart.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/p_result_uart_if.sv
// Result-to-UART link: 64-bit cipher result handshake plus the serial output.
// Ports: result[0:63] (bit 0 = MSB), result_valid, ready, uart_tx, done.
// master = producer of results / observer of the line, slave = the UART stage.
interface p_result_uart_if;
  logic [0:63] result;
  logic        result_valid;
  logic        ready;
  logic        uart_tx;
  logic        done;

  modport master (
    output result,
    output result_valid,
    input  ready,
    input  uart_tx,
    input  done
  );

  modport slave (
    input  result,
    input  result_valid,
    output ready,
    output uart_tx,
    output done
  );
endinterface

// File: rtl/p_result_uart.sv
// Purpose: sends a 64-bit PRESENT result as 16 uppercase ASCII hex chars (MSB nibble first) over 8N1 UART.
// Latency: start bit begins the cycle after acceptance; F*10*CLKS_PER_BIT cycles to done (F=16, 18 with CRLF).
// Backpressure: ready is low for the whole transfer; result_valid is ignored while ready=0.
// Ports: sys_clk, sys_rst (sync, active-high), bus (slave modport: result, result_valid, ready, uart_tx, done).
// Option: define P_RESULT_CRLF_EN to append CR (0x0D) and LF (0x0A) after the hex characters.
module p_result_uart #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  p_result_uart_if.slave bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
`ifdef P_RESULT_CRLF_EN
  localparam logic [4:0] LAST_CHAR = 5'd17;
`else
  localparam logic [4:0] LAST_CHAR = 5'd15;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q,  baud_d;
  logic [2:0]        bit_q,   bit_d;
  logic [4:0]        char_q,  char_d;
  logic [63:0]       data_q,  data_d;
  logic              tx_q,    tx_d;
  logic              done_q,  done_d;
  logic [7:0]        char_code;
  logic [2:0]        bit_nxt;
  logic              baud_end;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // The latched result is shifted left one nibble per character, so the
  // character being sent always comes from the top nibble.
  always_comb begin
    char_code = hex_ascii(data_q[63:60]);
`ifdef P_RESULT_CRLF_EN
    if (char_q == 5'd16) begin
      char_code = 8'h0D;
    end else if (char_q == 5'd17) begin
      char_code = 8'h0A;
    end
`endif
  end

  assign baud_end = (baud_q == BAUD_LAST);
  assign bit_nxt  = bit_q + 3'd1;

  // tx_d is the line level for the next cycle, so uart_tx comes straight
  // from a flop and each bit value is loaded at the boundary that starts it.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    char_d  = char_q;
    data_d  = data_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    if (state_q != IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (bus.result_valid) begin
          data_d  = bus.result;  // result[0] lands in data_d[63]
          state_d = START;
          tx_d    = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
          char_d  = '0;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = char_code[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nxt;
            tx_d  = char_code[bit_nxt];
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          if (char_q == LAST_CHAR) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = START;
            tx_d    = 1'b0;
            char_d  = char_q + 5'd1;
            data_d  = {data_q[59:0], 4'h0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      char_q  <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.uart_tx = tx_q;
  assign bus.done    = done_q;

endmodule
